hazard_scoreboard_ctrl: RTL

//   Issue/hazard sequencer for the pipelined datapath. Sits between the decode stage, where the

---
 rtl/hazard_scoreboard_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard_ctrl.sv
// Issue/hazard sequencer: per-register scoreboard with RAW/WAW stall and redirect flush window.
// Optional performance counters are enabled by defining HAZ_PERF_EN.
module hazard_scoreboard_ctrl #(
    parameter int NUM_REGS     = 16,
    parameter int CNT_W        = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dec_valid,
    input  logic [3:0]          dec_s1RegAddr,
    input  logic [3:0]          dec_s2RegAddr,
    input  logic                dec_usesS1,
    input  logic                dec_usesS2,
    input  logic [3:0]          dec_dRegAddr,
    input  logic                dec_regFileWrtEn,
    input  logic [1:0]          ex_pcSel,
    input  logic                wb_regFileWrtEn,
    input  logic [3:0]          wb_dRegAddr,
    output logic                issue,
    output logic                stall,
    output logic                flush,
    output logic [NUM_REGS-1:0] busyRegs,
    output logic                sbErr
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]         stallCycles,
    output logic [31:0]         flushCycles,
    output logic [31:0]         issueCount
`endif
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [FW-1:0]       flush_cnt_q;
    logic [FW-1:0]       flush_cnt_d;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                sb_err_q;
    logic                sb_err_d;

    logic redirect;
    logic flush_w;
    logic hazard;
    logic issue_w;
    logic stall_w;
    logic inc;
    logic dec;

    // Redirect detection, hazard check against pre-update counts, issue/stall decision
    always_comb begin
        redirect = (ex_pcSel != 2'b00);
        flush_w  = redirect | (flush_cnt_q != '0);
        hazard   = (dec_usesS1 & (cnt_q[dec_s1RegAddr] != '0))
                 | (dec_usesS2 & (cnt_q[dec_s2RegAddr] != '0))
                 | (dec_regFileWrtEn & (cnt_q[dec_dRegAddr] == '1));
        issue_w  = dec_valid & ~flush_w & ~hazard;
        stall_w  = dec_valid & ~flush_w & hazard;
        inc      = issue_w & dec_regFileWrtEn;
        dec      = wb_regFileWrtEn;
    end

    // Outputs are forced low while reset is asserted
    assign issue    = ~reset & issue_w;
    assign stall    = ~reset & stall_w;
    assign flush    = ~reset & flush_w;
    assign busyRegs = busy_q;
    assign sbErr    = sb_err_q;

    // Flush window counter: reload on redirect, otherwise count down to zero
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (redirect) begin
            flush_cnt_d = FLUSH_LOAD;
        end else if (flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - 1'b1;
        end
    end

    // Scoreboard next state; a matched issue/retire on one register cancels out
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        sb_err_d = sb_err_q;
        if (inc && dec && (dec_dRegAddr == wb_dRegAddr)) begin
            sb_err_d = sb_err_q;
        end else begin
            if (inc) begin
                cnt_d[dec_dRegAddr] = cnt_q[dec_dRegAddr] + 1'b1;
            end
            if (dec) begin
                if (cnt_q[wb_dRegAddr] != '0) begin
                    cnt_d[wb_dRegAddr] = cnt_q[wb_dRegAddr] - 1'b1;
                end else begin
                    sb_err_d = 1'b1;
                end
            end
        end
    end

    // Busy vector reflects the post-update counts
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_d[i] = (cnt_d[i] != '0);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            flush_cnt_q <= '0;
            busy_q      <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            flush_cnt_q <= flush_cnt_d;
            busy_q      <= busy_d;
            sb_err_q    <= sb_err_d;
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_cycles_q;
    logic [31:0] issue_count_q;

    // Free-running event counters, wrapping at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
            issue_count_q  <= '0;
        end else begin
            if (stall_w) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (flush_w) begin
                flush_cycles_q <= flush_cycles_q + 32'd1;
            end
            if (issue_w) begin
                issue_count_q <= issue_count_q + 32'd1;
            end
        end
    end

    assign stallCycles = stall_cycles_q;
    assign flushCycles = flush_cycles_q;
    assign issueCount  = issue_count_q;
`endif

endmodule
